mul_sched: RTL

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/mul_sched.sv
// Two-requester round-robin scheduler around one MSB-first shift-add multiplier.
// A grant captures the winner's operands; the product appears W RUN edges later and is held until ack.
module mul_sched #(
   parameter int W = 8
) (
   input  logic           ck,
   input  logic           rst_n,
   input  logic           req0,
   input  logic [W-1:0]   a0,
   input  logic [W-1:0]   b0,
   input  logic           req1,
   input  logic [W-1:0]   a1,
   input  logic [W-1:0]   b1,
   input  logic           ack,
   output logic           gnt0,
   output logic           gnt1,
   output logic           busy,
   output logic           vld,
   output logic [2*W-1:0] res,
   output logic           rid
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            ptr;
   logic            take;
   logic            win;
   logic            last;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_l;
   logic [2*W-1:0]  acc;
   logic [2*W-1:0]  sum;
   logic [CW-1:0]   cnt;

   // a_sh shifts left once per RUN edge, so its MSB is always the latched a bit [W-1-cnt]
   assign last = (cnt == CW'(W - 1));
   assign sum  = {acc[2*W-2:0], 1'b0} + (a_sh[W-1] ? {{W{1'b0}}, b_l} : {(2*W){1'b0}});

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req0 || req1) state_nxt = RUN;
         RUN:     if (last)         state_nxt = DONE;
         DONE:    if (ack)          state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // On a tie the pointer decides; a lone request wins outright
   always_comb begin
      busy = (state != IDLE);
      take = (state == IDLE) && (req0 || req1);
      win  = (req0 && req1) ? ptr : req1;
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         vld  <= 1'b0;
         res  <= '0;
         rid  <= 1'b0;
         ptr  <= 1'b0;
         acc  <= '0;
         cnt  <= '0;
         a_sh <= '0;
         b_l  <= '0;
      end else begin
         gnt0 <= take && !win;
         gnt1 <= take && win;
         unique case (state)
            IDLE: begin
               if (take) begin
                  a_sh <= win ? a1 : a0;
                  b_l  <= win ? b1 : b0;
                  rid  <= win;
                  ptr  <= !win;
                  acc  <= '0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               acc  <= sum;
               a_sh <= a_sh << 1;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  res <= sum;
                  vld <= 1'b1;
               end
            end
            DONE: begin
               if (ack) vld <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
